vga_write_arbiter: RTL and testbench

Shares the single VGA adapter write port (x, y, colour, plot) between three drawing engines: background copier (requester 0), sprite drawer (requester 1), and bomb/explosion drawer (requester 2). Each engine requests the port, receives an exclusive burst grant, streams pixels and signals done. The arbiter rotates priority round-robin, revokes stalled owners via a watchdog, and registers the pixel stream into the adapter. It sits between the drawing datapath and the VGA adapter, under the game control FSM.

---
 rtl/vga_write_arbiter.sv | 275 +++++++++++++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_write_arbiter.sv
//-----------------------------------------------------------------------------
// vga_write_arbiter
//
// Shares the single VGA adapter write port between three drawing engines:
//   requester 0 : background copier
//   requester 1 : sprite drawer
//   requester 2 : bomb / explosion drawer
//
// An engine raises req, gets an exclusive burst grant, streams pixels with
// plot and ends the burst with done. Priority rotates round-robin, starting
// the search one past the last owner. A watchdog revokes an owner that holds
// the port for MAX_IDLE cycles without plotting. Every owner release is
// followed by one GAP cycle so two engines never own the port back to back.
//
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   req[2:0]                level request per requester
//   plot[2:0]               pixel valid per requester
//   done[2:0]               burst-end strobe per requester
//   x_in/y_in/c_in          packed pixel fields, requester i at [i*W +: W]
//   grant[2:0]              one-hot owner (or zero), registered
//   vga_x/vga_y/vga_colour  registered pixel to the adapter
//   vga_plot                registered adapter write enable
//   busy                    high in OWN and GAP
//   timeout                 one-cycle pulse on watchdog revocation
//   stray_plot              sticky flag: plot from a non-owner
//   burst_len               pixels forwarded in current/last burst (saturating)
//-----------------------------------------------------------------------------
module vga_write_arbiter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int MAX_IDLE = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [2:0]       plot,
  input  logic [2:0]       done,
  input  logic [3*X_W-1:0] x_in,
  input  logic [3*Y_W-1:0] y_in,
  input  logic [3*C_W-1:0] c_in,
  output logic [2:0]       grant,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [C_W-1:0]   vga_colour,
  output logic             vga_plot,
  output logic             busy,
  output logic             timeout,
  output logic             stray_plot,
  output logic [15:0]      burst_len
);

  localparam logic [15:0] LP_MAX_IDLE = 16'(MAX_IDLE);
  localparam logic [15:0] LP_SAT      = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  //---------------------------------------------------------------------------
  // Registers
  //---------------------------------------------------------------------------
  state_t         r_state;
  logic [2:0]     r_grant;
  logic [1:0]     r_owner;     // index of the current owner, valid in OWN
  logic [1:0]     r_last;      // last owner; search starts at r_last+1
  logic [15:0]    r_idle_cnt;
  logic [15:0]    r_burst_len;
  logic [X_W-1:0] r_vga_x;
  logic [Y_W-1:0] r_vga_y;
  logic [C_W-1:0] r_vga_colour;
  logic           r_vga_plot;
  logic           r_timeout;
  logic           r_stray;

  //---------------------------------------------------------------------------
  // Next-state wires
  //---------------------------------------------------------------------------
  state_t         w_state_next;
  logic [2:0]     w_grant_next;
  logic [1:0]     w_owner_next;
  logic [1:0]     w_last_next;
  logic [15:0]    w_idle_next;
  logic [15:0]    w_burst_next;
  logic           w_fwd;
  logic           w_timeout_next;

  // Round-robin search
  logic [1:0]     w_order [3];
  logic [1:0]     w_pick;
  logic           w_found;

  // Owner-side decode
  logic           w_own_plot;
  logic           w_own_done;
  logic           w_own_req;
  logic           w_expire;
  logic [2:0]     w_owner_mask;
  logic           w_stray_hit;

  //---------------------------------------------------------------------------
  // Round-robin candidate order: start one past the last owner.
  //---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first so no path leaves it unassigned (which would infer a latch).
    w_order[0] = 2'd0;
    w_order[1] = 2'd1;
    w_order[2] = 2'd2;
    case (r_last)
      2'd0: begin
        w_order[0] = 2'd1;
        w_order[1] = 2'd2;
        w_order[2] = 2'd0;
      end
      2'd1: begin
        w_order[0] = 2'd2;
        w_order[1] = 2'd0;
        w_order[2] = 2'd1;
      end
      default: begin
        w_order[0] = 2'd0;
        w_order[1] = 2'd1;
        w_order[2] = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_pick  = 2'd0;
    w_found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!w_found && req[w_order[k]]) begin
        w_found = 1'b1;
        w_pick  = w_order[k];
      end
    end
  end

  //---------------------------------------------------------------------------
  // Owner-side decode and stray detection
  //---------------------------------------------------------------------------
  assign w_own_plot = plot[r_owner];
  assign w_own_done = done[r_owner];
  assign w_own_req  = req[r_owner];

  // r_idle_cnt never exceeds MAX_IDLE-1, so the increment cannot wrap.
  assign w_expire = (r_idle_cnt + 16'd1) >= LP_MAX_IDLE;

  // Only the registered owner in OWN may plot; anything else is a stray.
  assign w_owner_mask = (r_state == ST_OWN) ? r_grant : 3'b000;
  assign w_stray_hit  = |(plot & ~w_owner_mask);

  //---------------------------------------------------------------------------
  // Next-state / datapath control
  //---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_owner_next   = r_owner;
    w_last_next    = r_last;
    w_idle_next    = r_idle_cnt;
    w_burst_next   = r_burst_len;
    w_fwd          = 1'b0;
    w_timeout_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_next = 3'b001 << w_pick;
          w_owner_next = w_pick;
          w_idle_next  = 16'd0;
          w_burst_next = 16'd0;
          w_state_next = ST_OWN;
        end
      end

      ST_OWN: begin
        if (w_own_done) begin
          // done wins over both an aborted request and watchdog expiry;
          // a same-cycle plot is still the last pixel of the burst.
          w_fwd        = w_own_plot;
          w_grant_next = 3'b000;
          w_last_next  = r_owner;
          w_state_next = ST_GAP;
        end else if (!w_own_req) begin
          // Owner abandoned the burst: its same-cycle pixel is discarded.
          w_grant_next = 3'b000;
          w_last_next  = r_owner;
          w_state_next = ST_GAP;
        end else if (w_own_plot) begin
          w_fwd       = 1'b1;
          w_idle_next = 16'd0;
        end else if (w_expire) begin
          w_grant_next   = 3'b000;
          w_last_next    = r_owner;
          w_timeout_next = 1'b1;
          w_state_next   = ST_GAP;
        end else begin
          w_idle_next = r_idle_cnt + 16'd1;
        end

        if (w_fwd && (r_burst_len != LP_SAT)) begin
          w_burst_next = r_burst_len + 16'd1;
        end
      end

      ST_GAP: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_grant_next = 3'b000;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  //---------------------------------------------------------------------------
  // State and datapath registers
  //---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 3'b000;
      r_owner      <= 2'd0;
      r_last       <= 2'd2;  // requester 0 gets first priority after reset
      r_idle_cnt   <= 16'd0;
      r_burst_len  <= 16'd0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_timeout    <= 1'b0;
      r_stray      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_owner     <= w_owner_next;
      r_last      <= w_last_next;
      r_idle_cnt  <= w_idle_next;
      r_burst_len <= w_burst_next;
      r_vga_plot  <= w_fwd;
      r_timeout   <= w_timeout_next;
      if (w_stray_hit) begin
        r_stray <= 1'b1;
      end
      // Pixel fields hold their last forwarded value between plots.
      if (w_fwd) begin
        r_vga_x      <= x_in[r_owner*X_W +: X_W];
        r_vga_y      <= y_in[r_owner*Y_W +: Y_W];
        r_vga_colour <= c_in[r_owner*C_W +: C_W];
      end
    end
  end

  //---------------------------------------------------------------------------
  // Outputs
  //---------------------------------------------------------------------------
  assign grant      = r_grant;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign busy       = (r_state != ST_IDLE);
  assign timeout    = r_timeout;
  assign stray_plot = r_stray;
  assign burst_len  = r_burst_len;

endmodule

// File: tb/tb_vga_write_arbiter.sv
//-----------------------------------------------------------------------------
// tb_vga_write_arbiter
//
// Self-checking bench. Pixels that must reach the adapter are pushed to a
// scoreboard queue when driven; a monitor pops and compares one entry for
// every vga_plot pulse. Control outputs are checked directly per cycle.
//-----------------------------------------------------------------------------
module tb_vga_write_arbiter;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pix_t;

  logic             clock;
  logic             reset;
  logic [2:0]       req;
  logic [2:0]       plot;
  logic [2:0]       done;
  logic [3*X_W-1:0] x_in;
  logic [3*Y_W-1:0] y_in;
  logic [3*C_W-1:0] c_in;
  logic [2:0]       grant;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [C_W-1:0]   vga_colour;
  logic             vga_plot;
  logic             busy;
  logic             timeout;
  logic             stray_plot;
  logic [15:0]      burst_len;

  int   n_checks = 0;
  int   n_bad    = 0;
  pix_t sb_q[$];

  vga_write_arbiter #(
    .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .MAX_IDLE(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req(req), .plot(plot), .done(done),
    .x_in(x_in), .y_in(y_in), .c_in(c_in),
    .grant(grant),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .timeout(timeout), .stray_plot(stray_plot),
    .burst_len(burst_len)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pix(input int i, input logic [X_W-1:0] x,
                         input logic [Y_W-1:0] y, input logic [C_W-1:0] c);
    x_in[i*X_W +: X_W] = x;
    y_in[i*Y_W +: Y_W] = y;
    c_in[i*C_W +: C_W] = c;
    plot[i]            = 1'b1;
  endtask

  task automatic push(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                      input logic [C_W-1:0] c);
    pix_t p;
    p.x = x;
    p.y = y;
    p.c = c;
    sb_q.push_back(p);
  endtask

  // Scoreboard monitor: every adapter write must match the oldest expected.
  initial begin
    pix_t exp_p;
    pix_t got_p;
    forever begin
      tick();
      if (vga_plot) begin
        got_p = {vga_x, vga_y, vga_colour};
        if (sb_q.size() == 0) begin
          check("sb_unexpected_pixel", 32'(got_p), 32'hFFFF_FFFF);
        end else begin
          exp_p = sb_q.pop_front();
          check("sb_pixel", 32'(got_p), 32'(exp_p));
        end
      end
    end
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [2:0] rr_exp [4];
    int g;
    rr_exp[0] = 3'b001;
    rr_exp[1] = 3'b010;
    rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001;

    reset = 1'b1;
    req   = '0;
    plot  = '0;
    done  = '0;
    x_in  = '0;
    y_in  = '0;
    c_in  = '0;
    tick();
    tick();

    // Reset state
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_vga_plot", 32'(vga_plot), 32'd0);
    check("rst_vga_xyc", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_stray", 32'(stray_plot), 32'd0);
    check("rst_burst_len", 32'(burst_len), 32'd0);
    reset = 1'b0;
    tick();

    // Round-robin: all request, each owner does a single-cycle burst.
    req = 3'b111;
    tick();
    check("rr_grant_0", 32'(grant), 32'(rr_exp[0]));
    for (int k = 0; k < 4; k++) begin
      g = k % 3;
      set_pix(g, X_W'(20 + k), 7'd10, C_W'(k));
      push(X_W'(20 + k), 7'd10, C_W'(k));
      done[g] = 1'b1;
      tick();
      check("rr_release_grant", 32'(grant), 32'd0);
      check("rr_gap_busy", 32'(busy), 32'd1);
      check("rr_burst_len", 32'(burst_len), 32'd1);
      plot = '0;
      done = '0;
      if (k == 3) req = '0;
      tick();
      check("rr_idle_grant", 32'(grant), 32'd0);
      check("rr_idle_busy", 32'(busy), 32'd0);
      tick();
      if (k < 3) check("rr_next_grant", 32'(grant), 32'(rr_exp[k+1]));
    end

    // Single request with a 4-pixel burst.
    req = 3'b001;
    tick();
    check("single_grant", 32'(grant), 32'b001);
    for (int p = 0; p < 4; p++) begin
      set_pix(0, X_W'(10 + p), 7'd5, 3'd3);
      push(X_W'(10 + p), 7'd5, 3'd3);
      tick();
      check("single_vga_plot", 32'(vga_plot), 32'd1);
    end
    plot = '0;
    done = 3'b001;
    tick();
    check("single_release", 32'(grant), 32'd0);
    check("single_burst_len", 32'(burst_len), 32'd4);
    check("single_no_plot", 32'(vga_plot), 32'd0);
    check("single_held_x", 32'(vga_x), 32'd13);
    done = '0;
    req  = '0;
    tick();
    tick();

    // Watchdog: owner 1 never plots.
    req = 3'b010;
    tick();
    check("wd_grant", 32'(grant), 32'b010);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("wd_still_owned", 32'(grant), 32'b010);
      check("wd_no_timeout", 32'(timeout), 32'd0);
    end
    tick();
    check("wd_revoked", 32'(grant), 32'd0);
    check("wd_timeout_pulse", 32'(timeout), 32'd1);
    check("wd_no_plot", 32'(vga_plot), 32'd0);
    req = '0;
    tick();
    check("wd_timeout_cleared", 32'(timeout), 32'd0);
    tick();

    // Stray plot from requester 2 while requester 1 owns.
    req = 3'b010;
    tick();
    check("stray_grant", 32'(grant), 32'b010);
    set_pix(1, 8'd40, 7'd7, 3'd5);
    push(8'd40, 7'd7, 3'd5);
    set_pix(2, 8'd99, 7'd9, 3'd6);
    tick();
    check("stray_set", 32'(stray_plot), 32'd1);
    plot = '0;
    done = 3'b010;
    tick();
    check("stray_release", 32'(grant), 32'd0);
    check("stray_held_x", 32'(vga_x), 32'd40);
    done = '0;
    req  = '0;
    tick();
    tick();
    check("stray_sticky", 32'(stray_plot), 32'd1);

    // Owner aborts: req drops with plot high, pixel must not appear.
    req = 3'b001;
    tick();
    check("abort_grant", 32'(grant), 32'b001);
    set_pix(0, 8'd77, 7'd1, 3'd1);
    req = '0;
    tick();
    check("abort_release", 32'(grant), 32'd0);
    check("abort_gap_busy", 32'(busy), 32'd1);
    check("abort_no_timeout", 32'(timeout), 32'd0);
    check("abort_no_plot", 32'(vga_plot), 32'd0);
    check("abort_burst_len", 32'(burst_len), 32'd0);
    plot = '0;
    tick();
    tick();

    // Asynchronous reset in the middle of a burst.
    req = 3'b001;
    tick();
    check("areset_grant", 32'(grant), 32'b001);
    set_pix(0, 8'd50, 7'd2, 3'd2);
    push(8'd50, 7'd2, 3'd2);
    tick();
    check("areset_plot_before", 32'(vga_plot), 32'd1);
    set_pix(0, 8'd51, 7'd2, 3'd2);  // in flight, lost to reset
    #2;
    reset = 1'b1;
    #1;
    check("areset_grant_clr", 32'(grant), 32'd0);
    check("areset_plot_clr", 32'(vga_plot), 32'd0);
    check("areset_busy_clr", 32'(busy), 32'd0);
    check("areset_burst_clr", 32'(burst_len), 32'd0);
    check("areset_stray_clr", 32'(stray_plot), 32'd0);
    plot = '0;
    req  = 3'b101;
    tick();
    reset = 1'b0;
    tick();
    check("areset_prio_r0", 32'(grant), 32'b001);
    done = 3'b001;
    req  = 3'b100;
    tick();
    check("areset_release", 32'(grant), 32'd0);
    done = '0;
    tick();
    tick();
    check("areset_grant_r2", 32'(grant), 32'b100);
    done = 3'b100;
    tick();
    done = '0;
    req  = '0;
    tick();
    tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
